// File: rtl/buf_share_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit output buffer among N valid/ready requesters.
// Optional macro BUF_SHARE_IDLE_VALUE_EN drives IDLE_VALUE on O while the buffer is empty.
module buf_share_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned IDLE_VALUE = 1,
  localparam int unsigned PW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N-1:0]         I_valid,
  input  logic [N*WIDTH-1:0]   I_data,
  output logic [N-1:0]         I_ready,
  output logic [WIDTH-1:0]     O,
  output logic                 O_valid,
  input  logic                 O_ready,
  output logic [PW-1:0]        grant_id
);

`ifdef BUF_SHARE_IDLE_VALUE_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif

  // Empty-buffer value of the data register; also the constant idle source when enabled.
  localparam logic [WIDTH-1:0] RST_DATA = IDLE_EN ? WIDTH'(IDLE_VALUE) : '0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [PW-1:0]     gid_q, gid_d;
  logic [PW-1:0]     ptr_q, ptr_d;

  logic              can_accept;
  logic              found;
  logic              xfer;
  logic [PW-1:0]     win;
  logic [WIDTH-1:0]  win_data;
  int unsigned       idx;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= EMPTY;
      data_q  <= RST_DATA;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  // Arbitration, handshake and next-state logic.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    gid_d      = gid_q;
    ptr_d      = ptr_q;
    I_ready    = '0;
    found      = 1'b0;
    win        = '0;
    win_data   = '0;
    idx        = 0;
    can_accept = (state_q == EMPTY) || O_ready;

    // First valid requester at or after ptr, wrapping modulo N.
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && I_valid[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end

    for (int unsigned k = 0; k < N; k++) begin
      if (win == PW'(k)) begin
        win_data = I_data[k*WIDTH +: WIDTH];
      end
    end

    xfer = found && can_accept && !RESET;

    if (xfer) begin
      I_ready = N'(1) << win;
      state_d = FULL;
      data_d  = win_data;
      gid_d   = win;
      ptr_d   = (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end else if ((state_q == FULL) && O_ready) begin
      state_d = EMPTY;
    end
  end

  assign O_valid  = (state_q == FULL);
  assign grant_id = gid_q;

`ifdef BUF_SHARE_IDLE_VALUE_EN
  assign O = O_valid ? data_q : RST_DATA;
`else
  assign O = data_q;
`endif

endmodule

// File: tb/tb_buf_share_arbiter.sv
// Self-checking bench for buf_share_arbiter (N=4, WIDTH=2): directed vector table plus random traffic,
// with a reference model and a scoreboard of granted words.
module tb_buf_share_arbiter;

  logic       CLK;
  logic       RESET;
  logic [3:0] I_valid;
  logic [7:0] I_data;
  logic [3:0] I_ready;
  logic [1:0] O;
  logic       O_valid;
  logic       O_ready;
  logic [1:0] grant_id;

  buf_share_arbiter #(.N(4), .WIDTH(2), .IDLE_VALUE(1)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .I_valid  (I_valid),
    .I_data   (I_data),
    .I_ready  (I_ready),
    .O        (O),
    .O_valid  (O_valid),
    .O_ready  (O_ready),
    .grant_id (grant_id)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [7:0] data;
    logic       ordy;
    logic [3:0] exp_ir;
    logic [1:0] exp_gid;
  } vec_t;

  typedef struct {
    logic [1:0] data;
    logic [1:0] gid;
  } sb_t;

  vec_t tbl [27];
  sb_t  sb [$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       m_valid = 1'b0;
  logic [1:0] m_o     = 2'd0;
  logic [1:0] m_gid   = 2'd0;
  int         m_ptr   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] v, input logic [7:0] d, input logic ordy,
                      input bit has_exp, input logic [3:0] e_ir, input logic [1:0] e_gid);
    logic [3:0] m_ir;
    logic [1:0] exp_o;
    int         w;
    bit         can;
    bit         xfer;
    sb_t        e;
    @(negedge CLK);
    RESET = rst; I_valid = v; I_data = d; O_ready = ordy;
    #1;
    can = !m_valid || ordy;
    w = -1;
    for (int i = 0; i < 4; i++) begin
      if (w < 0 && v[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
    end
    m_ir = (!rst && can && w >= 0) ? 4'(1 << w) : 4'b0000;
    chk("i_ready_model", 8'(I_ready), 8'(m_ir));
    if (has_exp) chk("i_ready_vec", 8'(I_ready), 8'(e_ir));
    xfer = (m_ir != 4'b0000);
    if (rst) begin
      m_valid = 1'b0; m_o = 2'd0; m_gid = 2'd0; m_ptr = 0;
      sb.delete();
    end else if (xfer) begin
      sb.push_back('{data: d[w*2 +: 2], gid: 2'(w)});
      m_valid = 1'b1; m_o = d[w*2 +: 2]; m_gid = 2'(w); m_ptr = (w + 1) % 4;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    @(posedge CLK);
    #1;
    chk("o_valid", 8'(O_valid), 8'(m_valid));
    chk("grant_model", 8'(grant_id), 8'(m_gid));
    if (has_exp) chk("grant_vec", 8'(grant_id), 8'(e_gid));
    if (xfer) begin
      e = sb.pop_front();
      chk("sb_data", 8'(O), 8'(e.data));
      chk("sb_gid", 8'(grant_id), 8'(e.gid));
    end else begin
`ifdef BUF_SHARE_IDLE_VALUE_EN
      exp_o = m_valid ? m_o : 2'h1;
`else
      exp_o = m_o;
`endif
      chk("o_hold", 8'(O), 8'(exp_o));
    end
  endtask

  initial begin
    RESET = 1'b1; I_valid = 4'b0; I_data = 8'h0; O_ready = 1'b0;

    // {rst, valid, data, O_ready, expected I_ready, expected grant_id after edge}
    tbl[0]  = '{1'b1, 4'b1111, 8'hE4, 1'b1, 4'b0000, 2'd0};
    tbl[1]  = '{1'b1, 4'b1111, 8'hE4, 1'b1, 4'b0000, 2'd0};
    tbl[2]  = '{1'b0, 4'b1111, 8'hE4, 1'b1, 4'b0001, 2'd0};
    tbl[3]  = '{1'b0, 4'b1111, 8'hE4, 1'b1, 4'b0010, 2'd1};
    tbl[4]  = '{1'b0, 4'b1111, 8'hE4, 1'b1, 4'b0100, 2'd2};
    tbl[5]  = '{1'b0, 4'b1111, 8'hE4, 1'b1, 4'b1000, 2'd3};
    tbl[6]  = '{1'b0, 4'b1111, 8'hE4, 1'b1, 4'b0001, 2'd0};
    tbl[7]  = '{1'b0, 4'b1111, 8'hE4, 1'b1, 4'b0010, 2'd1};
    tbl[8]  = '{1'b0, 4'b1111, 8'hE4, 1'b1, 4'b0100, 2'd2};
    tbl[9]  = '{1'b0, 4'b1111, 8'hE4, 1'b1, 4'b1000, 2'd3};
    // Requester 2 sends 3, then stall with 0 and 1 pending; release grants 0 after wrap
    tbl[10] = '{1'b0, 4'b0100, 8'h30, 1'b1, 4'b0100, 2'd2};
    tbl[11] = '{1'b0, 4'b0011, 8'h09, 1'b0, 4'b0000, 2'd2};
    tbl[12] = '{1'b0, 4'b0011, 8'h09, 1'b0, 4'b0000, 2'd2};
    tbl[13] = '{1'b0, 4'b0011, 8'h09, 1'b0, 4'b0000, 2'd2};
    tbl[14] = '{1'b0, 4'b0011, 8'h09, 1'b0, 4'b0000, 2'd2};
    tbl[15] = '{1'b0, 4'b0011, 8'h09, 1'b0, 4'b0000, 2'd2};
    tbl[16] = '{1'b0, 4'b0011, 8'h09, 1'b1, 4'b0001, 2'd0};
    // Drain to empty
    tbl[17] = '{1'b0, 4'b0000, 8'h09, 1'b1, 4'b0000, 2'd0};
    tbl[18] = '{1'b0, 4'b0000, 8'h09, 1'b1, 4'b0000, 2'd0};
    // Reset in the middle of a stall
    tbl[19] = '{1'b0, 4'b0010, 8'h08, 1'b0, 4'b0010, 2'd1};
    tbl[20] = '{1'b0, 4'b0010, 8'h08, 1'b0, 4'b0000, 2'd1};
    tbl[21] = '{1'b1, 4'b1111, 8'hE4, 1'b0, 4'b0000, 2'd0};
    tbl[22] = '{1'b0, 4'b0110, 8'hE4, 1'b0, 4'b0010, 2'd1};
    // Sparse: only requester 3 from ptr=0, then ptr wraps to 0
    tbl[23] = '{1'b1, 4'b0000, 8'h00, 1'b1, 4'b0000, 2'd0};
    tbl[24] = '{1'b0, 4'b1000, 8'h80, 1'b1, 4'b1000, 2'd3};
    tbl[25] = '{1'b0, 4'b0001, 8'h80, 1'b1, 4'b0001, 2'd0};
    tbl[26] = '{1'b0, 4'b0000, 8'h80, 1'b1, 4'b0000, 2'd0};

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].ordy, 1'b1, tbl[i].exp_ir, tbl[i].exp_gid);
    end

    // Random traffic against the model, with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 4'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
           1'b0, 4'b0000, 2'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
